// File: rtl/alu_result_sink.sv
// Result sink after the ALU: FWFT FIFO of {Result, ALUFlags, ALUControl} with Z-count and sticky-flag statistics.
// Define ALU_SINK_STICKY_FLAGS_EN to build the sticky flag register; otherwise sticky_flags is tied to zero.
module alu_result_sink #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         Result,
    input  logic [3:0]               ALUFlags,
    input  logic [2:0]               ALUControl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [2:0]               out_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               zero_cnt,
    output logic [3:0]               sticky_flags,
    input  logic                     clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [3:0]       mem_flags  [DEPTH];
    logic [2:0]       mem_op     [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // in_ready looks only at registered count, so a pop never frees a slot in the same cycle
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result = out_valid ? mem_result[rd_ptr] : '0;
    assign out_flags  = out_valid ? mem_flags[rd_ptr]  : '0;
    assign out_op     = out_valid ? mem_op[rd_ptr]     : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= Result;
            mem_flags[wr_ptr]  <= ALUFlags;
            mem_op[wr_ptr]     <= ALUControl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_cnt <= '0;
        end else if (clr) begin
            zero_cnt <= '0;
        end else if (push && ALUFlags[2] && (zero_cnt != 8'hFF)) begin
            zero_cnt <= zero_cnt + 8'd1;
        end
    end

`ifdef ALU_SINK_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= '0;
        end else if (clr) begin
            sticky_flags <= '0;
        end else if (push) begin
            sticky_flags <= sticky_flags | ALUFlags;
        end
    end
`else
    assign sticky_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_sink.sv
// Self-checking bench for alu_result_sink: vector table plus scoreboard queue of expected FIFO entries.
module tb_alu_result_sink;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] Result;
    logic [3:0] ALUFlags;
    logic [2:0] ALUControl;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_op;
    logic [2:0] count;
    logic [7:0] zero_cnt;
    logic [3:0] sticky_flags;
    logic       clr;

    alu_result_sink #(.WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .ALUFlags(ALUFlags), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_op(out_op), .count(count),
        .zero_cnt(zero_cnt), .sticky_flags(sticky_flags), .clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [11:0] sb[$];
    int          m_zc;
    logic [3:0]  m_st;

    typedef struct {
        logic       iv;
        logic [4:0] res;
        logic [3:0] fl;
        logic [2:0] op;
        logic       ordy;
        logic       c;
        int         exp_cnt;
        int         exp_zc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called at a negedge; drives one cycle and checks outputs before and after the edge
    task automatic cyc(input logic iv, input logic [4:0] r, input logic [3:0] f,
                       input logic [2:0] o, input logic ordy, input logic c);
        logic        m_push;
        logic        m_pop;
        logic [11:0] head;
        in_valid = iv; Result = r; ALUFlags = f; ALUControl = o; out_ready = ordy; clr = c;
        #1;
        check("in_ready", int'(in_ready), int'(sb.size() != 4));
        check("out_valid", int'(out_valid), int'(sb.size() != 0));
        head = (sb.size() != 0) ? sb[0] : 12'h000;
        check("out_result", int'(out_result), int'(head[11:7]));
        check("out_flags", int'(out_flags), int'(head[6:3]));
        check("out_op", int'(out_op), int'(head[2:0]));
        m_push = iv && (sb.size() != 4);
        m_pop  = ordy && (sb.size() != 0);
        @(posedge clk);
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({r, f, o});
        if (c) m_zc = 0;
        else if (m_push && f[2] && m_zc != 255) m_zc++;
`ifdef ALU_SINK_STICKY_FLAGS_EN
        if (c) m_st = 4'b0000;
        else if (m_push) m_st = m_st | f;
`else
        m_st = 4'b0000;
`endif
        @(negedge clk);
        check("count", int'(count), sb.size());
        check("zero_cnt", int'(zero_cnt), m_zc);
        check("sticky_flags", int'(sticky_flags), int'(m_st));
    endtask

    initial begin
        m_zc = 0; m_st = 4'b0000;
        reset = 1'b0; in_valid = 1'b0; Result = '0; ALUFlags = '0; ALUControl = '0;
        out_ready = 1'b0; clr = 1'b0;

        vecs[0]  = '{1'b1, 5'd8, 4'b0000, 3'd0, 1'b0, 1'b0, 1, 0};
        vecs[1]  = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 0, 0};
        vecs[2]  = '{1'b1, 5'd1, 4'b0100, 3'd1, 1'b0, 1'b0, 1, 1};
        vecs[3]  = '{1'b1, 5'd2, 4'b0100, 3'd2, 1'b0, 1'b0, 2, 2};
        vecs[4]  = '{1'b1, 5'd3, 4'b0100, 3'd3, 1'b0, 1'b0, 3, 3};
        vecs[5]  = '{1'b1, 5'd4, 4'b1010, 3'd4, 1'b0, 1'b0, 4, 3};
        vecs[6]  = '{1'b1, 5'd5, 4'b0100, 3'd5, 1'b0, 1'b0, 4, 3};
        vecs[7]  = '{1'b1, 5'd5, 4'b0100, 3'd5, 1'b1, 1'b0, 3, 3};
        vecs[8]  = '{1'b1, 5'd5, 4'b0100, 3'd5, 1'b0, 1'b0, 4, 4};
        vecs[9]  = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b1, 3, 0};
        vecs[10] = '{1'b1, 5'd6, 4'b0100, 3'd6, 1'b1, 1'b1, 3, 0};
        vecs[11] = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 2, 0};
        vecs[12] = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 1, 0};
        vecs[13] = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 0, 0};
        vecs[14] = '{1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_result", int'(out_result), 0);
        check("rst_out_flags", int'(out_flags), 0);
        check("rst_out_op", int'(out_op), 0);
        check("rst_count", int'(count), 0);
        check("rst_zero_cnt", int'(zero_cnt), 0);
        check("rst_sticky", int'(sticky_flags), 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].op, vecs[i].ordy, vecs[i].c);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_cnt);
            check($sformatf("vec%0d_zero_cnt", i), int'(zero_cnt), vecs[i].exp_zc);
`ifdef ALU_SINK_STICKY_FLAGS_EN
            if (i == 5) check("vec5_sticky", int'(sticky_flags), 4'b1110);
`endif
        end

        // streaming with both sides ready: occupancy must stay at one
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 5'(i), 4'b0000, 3'(i % 8), 1'b1, 1'b0);
            check("stream_count_le1", int'(count <= 3'd1), 1);
        end
        cyc(1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0);
        check("stream_drained", int'(count), 0);

        // zero_cnt saturation
        for (int i = 0; i < 260; i++) cyc(1'b1, 5'd0, 4'b0100, 3'd0, 1'b1, 1'b0);
        check("zero_cnt_sat", int'(zero_cnt), 255);
        cyc(1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0);

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'(20 + i), 4'b0100, 3'd7, 1'b0, 1'b0);
        check("pre_reset_count", int'(count), 3);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_zero_cnt", int'(zero_cnt), 0);
        check("async_rst_sticky", int'(sticky_flags), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        #1;
        reset = 1'b1;
        sb.delete(); m_zc = 0; m_st = 4'b0000;
        @(negedge clk);
        cyc(1'b1, 5'd17, 4'b0100, 3'd2, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 4'b0000, 3'd0, 1'b1, 1'b0);
        check("post_reset_count", int'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_sink.md
# alu_result_sink

Consumer end of the ALU datapath: accepts each ALU result (Result, ALUFlags, and the ALUControl code that produced it) through a valid/ready handshake. Results are buffered in a small first-word-fall-through FIFO and drained in order by a downstream reader. The block also keeps running statistics on accepted results. It sits directly after `top` (ALU plus shifter) and lets the datapath issue results faster than the reader drains them.

## Interface
- `WIDTH`, 5, Result width; matches the ALU operand width.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer presents a result this cycle.
- `in_ready`  out  1  sink can accept a result this cycle.
- `Result`  in  WIDTH  ALU result.
- `ALUFlags`  in  4  ALU flags, [3]=N, [2]=Z, [1]=C, [0]=V.
- `ALUControl`  in  3  opcode tag stored with the entry.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  reader consumes the head entry.
- `out_result`  out  WIDTH  head entry result.
- `out_flags`  out  4  head entry flags.
- `out_op`  out  3  head entry opcode.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `zero_cnt`  out  8  number of accepted entries with Z=1; saturates at 255.
- `sticky_flags`  out  4  OR of the flags of all accepted entries (see Configuration).
- `clr`  in  1  synchronous clear of `zero_cnt` and `sticky_flags`; the FIFO is unaffected.

## Operation
- Push occurs when `in_valid && in_ready`. The entry {Result, ALUFlags, ALUControl} is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop occurs when `out_valid && out_ready`. The read pointer increments modulo DEPTH.
- `in_ready = (count != DEPTH)`. When full, a simultaneous pop does not free a slot in the same cycle; `in_ready` stays low until the next cycle.
- `out_valid = (count != 0)`. The `out_*` outputs are driven combinationally from the entry at the read pointer (FWFT).
- Output value when empty: `out_result`, `out_flags` and `out_op` drive 0.
- `count` update on a cycle with both push and pop: unchanged, and both pointers advance.
- `count` update on push only: +1. On pop only: −1.
- Pop while empty is impossible, because `out_valid` is low and `out_ready` is ignored.
- `zero_cnt` increments on every push whose ALUFlags[2]=1 and holds at 255.
- `clr` takes priority over a same-cycle increment: the counter becomes 0, not 1.
- The same-cycle push is dropped from the statistics, but it is still stored in the FIFO.
- Reset in the middle of operation discards all FIFO contents immediately (asynchronous). Pointers, `count`, `zero_cnt` and `sticky_flags` all go to 0.
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_flags`=0, `out_op`=0, `count`=0, `zero_cnt`=0, `sticky_flags`=0.

## Timing
- Latency from a push to the entry appearing at `out_*`: 1 cycle. A push at edge k makes `out_valid` high after edge k when the FIFO was empty.
- No combinational path from `in_valid` to `out_valid`.
- `in_ready` depends only on registered `count`. No path from `out_ready` to `in_ready`.
- Throughput: one push and one pop per cycle in steady state, provided the FIFO is neither empty nor full.
- `zero_cnt` and `sticky_flags` reflect a push on the cycle after its accepting edge.
- Deassertion of `reset` is sampled on `clk`. The first push can occur on the first rising edge with `reset`=1.

## Configuration
- Macro: `ALU_SINK_STICKY_FLAGS_EN`.
- Defined: `sticky_flags` <= `sticky_flags | ALUFlags` on every push. `clr` zeros the register, and `clr` wins over a same-cycle push.
- Not defined: no sticky register is synthesized and `sticky_flags` is tied to 4'b0000. All other behaviour is identical.

## Test plan
- Single entry: reset, then push Result=8, ALUFlags=4'b0000, ALUControl=3'b000. Required: `out_valid`=1 and `out_result`=8 one cycle later, `count`=1. Pop, then `count`=0 and `out_valid`=0.
- Fill and full: push 4 entries (results 1,2,3,4) with `out_ready`=0. Required: `count`=4 and `in_ready`=0; a 5th push with `in_valid` held is not accepted. Drain yields 1,2,3,4 in order.
- Wrap-around: with `out_ready`=1 and `in_valid`=1 stream 10 results, 0..9. Required: output sequence 0..9, `count` never exceeds 1, both pointers wrap correctly.
- Full plus simultaneous pop: with `count`=4, assert `in_valid` and `out_ready`. Required: pop accepted, push refused that cycle, `count`=3; the push is accepted on the next cycle and `count`=4.
- Statistics: push 3 entries with Z=1, ALUFlags=4'b0100, then one with 4'b1010. Required: `zero_cnt`=3 and, with the macro defined, `sticky_flags`=4'b1110. `clr` on the same cycle as a Z=1 push gives `zero_cnt`=0.
- Reset mid-stream: with `count`=3, pulse `reset` low between edges. Required: `count`=0, `out_valid`=0 and `zero_cnt`=0 immediately, without waiting for a `clk` edge.
